// File: rtl/fb_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : fb_pipe_pkg
// Brief    : Shared state encoding, per-stage widths and payload field layout
//            for the fb_pipe_stage pipeline registers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fb_pipe_pkg;

    typedef logic [1:0] fb_state_t;

    localparam fb_state_t ST_EMPTY = 2'd0;
    localparam fb_state_t ST_BUSY  = 2'd1;
    localparam fb_state_t ST_FULL  = 2'd2;

    localparam int FB_IFID_CTRL_W  = 8;
    localparam int FB_IFID_DATA_W  = 64;
    localparam int FB_IDEX_CTRL_W  = 8;
    localparam int FB_IDEX_DATA_W  = 128;
    localparam int FB_EXMEM_CTRL_W = 8;
    localparam int FB_EXMEM_DATA_W = 104;
    localparam int FB_MEMWB_CTRL_W = 8;
    localparam int FB_MEMWB_DATA_W = 72;

    // ID/EX payload layout; every producer and consumer packs through these.
    localparam int FB_IDEX_PC_LSB  = 0;
    localparam int FB_IDEX_PC_W    = 32;
    localparam int FB_IDEX_RS1_LSB = 32;
    localparam int FB_IDEX_RS1_W   = 32;
    localparam int FB_IDEX_RS2_LSB = 64;
    localparam int FB_IDEX_RS2_W   = 32;
    localparam int FB_IDEX_IMM_LSB = 96;
    localparam int FB_IDEX_IMM_W   = 16;
    localparam int FB_IDEX_RD_LSB  = 112;
    localparam int FB_IDEX_RD_W    = 5;
    localparam int FB_IDEX_ALU_LSB = 117;
    localparam int FB_IDEX_ALU_W   = 4;

    typedef struct packed {
        logic [6:0]  spare;
        logic [3:0]  alu_ctl;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] rs2;
        logic [31:0] rs1;
        logic [31:0] pc;
    } fb_idex_t;

    function automatic logic [1:0] fb_occupancy(input fb_state_t st);
        case (st)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_pipe_entry.sv
//------------------------------------------------------------------------------
// Module   : fb_pipe_entry
// Brief    : One valid + control + payload register with load and clear controls.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_pipe_entry
    import fb_pipe_pkg::*;
#(
    parameter int CTRL_W = FB_IDEX_CTRL_W,
    parameter int DATA_W = FB_IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_valid_i,
    input  logic              clr_ctrl_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Clears win over load so a squash can never be overridden by a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            if (clr_valid_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end
            if (clr_ctrl_i) begin
                ctrl_q <= '0;
            end else if (load_i) begin
                ctrl_q <= ctrl_i;
            end
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/fb_pipe_stage.sv
//------------------------------------------------------------------------------
// Module   : fb_pipe_stage
// Brief    : Valid/ready pipeline-stage register with optional 2-entry skid,
//            flush and bubble insertion.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_pipe_stage
    import fb_pipe_pkg::*;
#(
    parameter int CTRL_W = FB_IDEX_CTRL_W,
    parameter int DATA_W = FB_IDEX_DATA_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              in_fire;
    logic              out_fire;
    logic [CTRL_W-1:0] cap_ctrl;

    logic              main_load;
    logic              main_clr_valid;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;
    assign cap_ctrl = bubble ? '0 : in_ctrl;

    fb_pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (main_load),
        .clr_valid_i (main_clr_valid),
        .clr_ctrl_i  (flush),
        .ctrl_i      (main_ld_ctrl),
        .data_i      (main_ld_data),
        .valid_o     (main_valid),
        .ctrl_o      (main_ctrl),
        .data_o      (out_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    generate
        if (SKID != 0) begin : g_skid
            fb_state_t         state_q;
            fb_state_t         state_d;
            logic              in_ready_q;
            logic              skid_load;
            logic              skid_clr_valid;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            fb_pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk         (clk),
                .rst_n       (rst_n),
                .load_i      (skid_load),
                .clr_valid_i (skid_clr_valid),
                .clr_ctrl_i  (flush),
                .ctrl_i      (cap_ctrl),
                .data_i      (in_data),
                .valid_o     (skid_valid),
                .ctrl_o      (skid_ctrl),
                .data_o      (skid_data)
            );

            always_comb begin
                state_d        = state_q;
                main_load      = 1'b0;
                main_clr_valid = flush;
                main_ld_ctrl   = cap_ctrl;
                main_ld_data   = in_data;
                skid_load      = 1'b0;
                skid_clr_valid = flush;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                main_load = 1'b1;
                                state_d   = ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (in_fire && out_fire) begin
                                main_load = 1'b1;
                            end else if (in_fire) begin
                                skid_load = 1'b1;
                                state_d   = ST_FULL;
                            end else if (out_fire) begin
                                main_clr_valid = 1'b1;
                                state_d        = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // Skid promotes into main; only a valid skid may carry side effects.
                            if (out_fire) begin
                                main_load      = 1'b1;
                                main_ld_ctrl   = skid_valid ? skid_ctrl : '0;
                                main_ld_data   = skid_data;
                                skid_clr_valid = 1'b1;
                                state_d        = ST_BUSY;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end
            end

            // in_ready is a flop so out_ready never reaches upstream combinationally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready  = in_ready_q;
            assign occupancy = fb_occupancy(state_q);
        end else begin : g_single
            assign in_ready = out_ready | ~main_valid;

            always_comb begin
                main_load      = in_fire & ~flush;
                main_clr_valid = flush | (out_fire & ~in_fire);
                main_ld_ctrl   = cap_ctrl;
                main_ld_data   = in_data;
            end

            assign occupancy = {1'b0, main_valid};
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/fb_pipe_stage.md
Name: fb_pipe_stage

Overview:
- Parametrised pipeline-stage register that generalises the fixed ID/EX latch.
- Carries a control field and a data payload between adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake and a 2-entry skid buffer, so a stall never drops an instruction and never costs throughput.
- Supports flush (squash) and bubble insertion; a bubble zeroes the control field while the data payload is still captured.

Parameters:
- CTRL_W, 8: width of the control field (mem_read, mem_write, reg_write, ...). All-zero means no side effects.
- DATA_W, 128: width of the data payload (pc, operands, immediates, register numbers, alu control).
- SKID, 1: 1 builds the 2-entry skid buffer; 0 builds a single register with combinational in_ready = out_ready | ~out_valid.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream holds a valid instruction.
- in_ready, output, 1: stage can accept this cycle. Registered when SKID=1.
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream payload.
- bubble, input, 1: the instruction accepted this cycle has its control field forced to 0 (load-use lock).
- flush, input, 1: squash all contents of this stage.
- out_valid, output, 1: main entry holds a valid instruction.
- out_ready, input, 1: downstream accepts this cycle.
- out_ctrl, output, CTRL_W: main entry control field; forced to 0 whenever out_valid=0.
- out_data, output, DATA_W: main entry payload.
- occupancy, output, 2: number of held entries, 0 to 2.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Both entries go invalid; all ctrl and data registers go to 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 after release.
  - Reset applied mid-transfer discards held entries; no partial state survives.
- Transfer events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Captured control value: bubble ? 0 : in_ctrl. The payload is always in_data.
- State machine (SKID=1):
  - EMPTY (occ 0):
    - in_fire: load main, go to BUSY.
  - BUSY (occ 1):
    - in_fire & out_fire: load main, stay in BUSY.
    - in_fire & ~out_fire: load skid, go to FULL.
    - ~in_fire & out_fire: go to EMPTY.
    - otherwise: hold.
  - FULL (occ 2):
    - in_ready=0.
    - out_fire: skid moves to main, go to BUSY.
    - otherwise: hold both entries.
- in_ready = (state != FULL), taken from a flop. No combinational path from out_ready to in_ready.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustained throughput is 1 per cycle while out_ready=1.
- Ordering is strictly FIFO; the skid entry is never presented before main.
- Flush:
  - Synchronous; has priority over every other event.
  - Next state is EMPTY and both valids clear. Ctrl registers clear; data registers may hold stale values.
  - An input offered in the flush cycle is dropped even if in_ready=1.
  - An out_fire in the flush cycle still counts as delivered this cycle; downstream owns its own flush.
- Bubble together with a stall: the bubble applies only if in_fire occurs. When in_ready=0, bubble has no effect and the upstream must keep driving it.
- Holding rule: while out_valid=1 and out_ready=0, out_ctrl and out_data stay stable.
- SKID=0 behaviour:
  - in_ready = out_ready | ~out_valid (combinational).
  - occupancy is 0 or 1.
  - The flush and bubble rules are unchanged.

Decomposition:
- Shared package fb_pipe_pkg:
  - State encoding localparams: ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - Per-stage CTRL_W and DATA_W constants: FB_IDEX_CTRL_W, FB_IDEX_DATA_W, and so on.
  - Field-offset constants so each stage packs and unpacks in_data consistently.
- One sub-module, fb_pipe_entry: a single valid+ctrl+data register with load, clear-valid and clear-ctrl controls. fb_pipe_stage instantiates it twice (main and skid), or once when SKID=0.

Test Plan:
- Streaming (defaults): in_valid=1 and out_ready=1 for 10 cycles, ctrl=8'h0F, data=0..9 -> out_valid from cycle 1; out_data=0..9 in order, one per cycle; occupancy stays 1; in_ready stays 1.
- Back-pressure: load A=0x11, then hold out_ready=0 and offer B=0x22 and C=0x33 -> B is taken into skid, occupancy=2, in_ready=0 and C is held upstream. Raise out_ready -> A, B, C appear in order with no loss or duplication.
- Bubble: in_ctrl=8'hFF, in_data=0xABCD, bubble=1 with in_fire -> out_valid=1, out_ctrl=0, out_data=0xABCD.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the offered input does not appear in a later cycle.
- Asynchronous reset mid-cycle while BUSY: pulse rst_n low between edges -> outputs go to 0 immediately, before the next edge; streaming resumes normally after release.
- SKID=0 build: drop out_ready while out_valid=1 -> in_ready=0 in the same cycle; the held output stays stable.
